imem_arbiter: RTL and testbench

- Shares one memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between ifetch/lsu and the memory or bus adapter. It speaks the same req/ready/valid/err handshake that ifetch drives on its imem side.
- One outstanding transaction at a time.
- Fixed priority D over I, with an anti-starvation limit, and a kill path for squashed fetches.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/imem_arb_prio.sv | 55 +++++
 rtl/imem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_imem_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the memory-port arbiter and the load/store unit.
package riscv_pkg;

    localparam int unsigned RV_XLEN     = 64;
    localparam int unsigned RV_ADDR_W   = 32;
    localparam int unsigned RV_STRB_W   = RV_XLEN / 8;
    localparam int unsigned BURST_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    // Memory request payload; the lsu builds the same struct.
    typedef struct packed {
        logic                  we;
        logic [RV_ADDR_W-1:0]  addr;
        logic [RV_XLEN-1:0]    wdata;
        logic [RV_STRB_W-1:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/imem_arb_prio.sv
// Priority pick between I and D requesters with an anti-starvation counter.
//   clk, reset   : clock, synchronous active-high reset
//   arb_en       : arbiter is in IDLE and may grant this cycle
//   i_req/i_kill : I request and flush (a killed I request is not eligible)
//   d_req        : D request
//   pick_i_c     : combinational, I wins this cycle
//   pick_d_c     : combinational, D wins this cycle
module imem_arb_prio
    import riscv_pkg::*;
#(
    parameter int unsigned D_BURST_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic i_req,
    input  logic i_kill,
    input  logic d_req,
    output logic pick_i_c,
    output logic pick_d_c
);

    logic [BURST_CNT_W-1:0] burst_cnt_q;
    logic                   i_elig;
    logic                   starve;

    // Fixed D priority unless I has waited out a full D burst.
    always_comb begin
        i_elig   = i_req && !i_kill;
        starve   = (burst_cnt_q >= BURST_CNT_W'(D_BURST_MAX));
        pick_i_c = 1'b0;
        pick_d_c = 1'b0;
        if (arb_en) begin
            if (d_req && i_elig) begin
                pick_i_c = starve;
                pick_d_c = !starve;
            end else begin
                pick_d_c = d_req;
                pick_i_c = i_elig;
            end
        end
    end

    // Counts D grants that went by while I was waiting; saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt_q <= '0;
        end else if (!i_req || pick_i_c) begin
            burst_cnt_q <= '0;
        end else if (pick_d_c && (burst_cnt_q != '1)) begin
            burst_cnt_q <= burst_cnt_q + BURST_CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// One outstanding transaction; D has priority, bounded by D_BURST_MAX.
//   clk, reset                       : clock, synchronous active-high reset
//   i_req/i_addr/i_kill              : I request, address, fetch flush
//   i_gnt/i_rvalid/i_rdata/i_err     : I grant pulse and response
//   d_req/d_we/d_addr/d_wdata/d_wstrb: D request and payload
//   d_gnt/d_rvalid/d_rdata/d_err     : D grant pulse and response
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : memory request (held until mem_ready)
//   mem_ready/mem_valid/mem_rdata/mem_err       : memory accept and response
// The latched payload uses the shared mem_req_t widths; XLEN/ADDR_W are
// expected to match the package.
module imem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned D_BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_kill,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [XLEN-1:0]     i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [XLEN-1:0]     d_wdata,
    input  logic [XLEN/8-1:0]   d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [XLEN-1:0]     d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_ready,
    input  logic                mem_valid,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_err
);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic                kill_q, kill_d;
    mem_req_t            pay_q, pay_d;
    logic                mem_req_q, mem_req_d;
    logic                i_gnt_q, i_gnt_d;
    logic                d_gnt_q, d_gnt_d;
    logic                i_rvalid_q, i_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [XLEN-1:0]     i_rdata_q, i_rdata_d;
    logic [XLEN-1:0]     d_rdata_q, d_rdata_d;
    logic                i_err_q, i_err_d;
    logic                d_err_q, d_err_d;
    logic                resp_fire;
    logic                kill_hit;
    logic                pick_i_c;
    logic                pick_d_c;

    imem_arb_prio #(
        .D_BURST_MAX (D_BURST_MAX)
    ) u_prio (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (state_q == IDLE),
        .i_req    (i_req),
        .i_kill   (i_kill),
        .d_req    (d_req),
        .pick_i_c (pick_i_c),
        .pick_d_c (pick_d_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        kill_d     = kill_q;
        pay_d      = pay_q;
        mem_req_d  = mem_req_q;
        i_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        i_err_d    = i_err_q;
        d_rdata_d  = d_rdata_q;
        d_err_d    = d_err_q;
        resp_fire  = 1'b0;
        kill_hit   = i_kill && (owner_q == OWN_I);

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (pick_d_c) begin
                    owner_d     = OWN_D;
                    pay_d.we    = d_we;
                    pay_d.addr  = RV_ADDR_W'(d_addr);
                    pay_d.wdata = RV_XLEN'(d_wdata);
                    pay_d.wstrb = RV_STRB_W'(d_wstrb);
                    d_gnt_d     = 1'b1;
                    mem_req_d   = 1'b1;
                    state_d     = ISSUE;
                end else if (pick_i_c) begin
                    owner_d     = OWN_I;
                    pay_d.we    = 1'b0;
                    pay_d.addr  = RV_ADDR_W'(i_addr);
                    pay_d.wdata = '0;
                    pay_d.wstrb = '0;
                    i_gnt_d     = 1'b1;
                    mem_req_d   = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                kill_d = kill_q | kill_hit;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    resp_fire = mem_valid;
                    state_d   = mem_valid ? RESP : WAIT;
                end
            end
            WAIT: begin
                kill_d = kill_q | kill_hit;
                if (mem_valid) begin
                    resp_fire = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                kill_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response is registered so x_rvalid is high exactly in RESP; a kill
        // arriving in the same cycle as mem_valid still drops the I response.
        if (resp_fire) begin
            if (owner_q == OWN_D) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = mem_rdata;
                d_err_d    = mem_err;
            end else if (!(kill_q || kill_hit)) begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = mem_rdata;
                i_err_d    = mem_err;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            kill_q     <= 1'b0;
            pay_q      <= '0;
            mem_req_q  <= 1'b0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            kill_q     <= kill_d;
            pay_q      <= pay_d;
            mem_req_q  <= mem_req_d;
            i_gnt_q    <= i_gnt_d;
            d_gnt_q    <= d_gnt_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_err_q    <= i_err_d;
            d_err_q    <= d_err_d;
        end
    end

    assign i_gnt     = i_gnt_q;
    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = pay_q.we;
    assign mem_addr  = ADDR_W'(pay_q.addr);
    assign mem_wdata = XLEN'(pay_q.wdata);
    assign mem_wstrb = (XLEN/8)'(pay_q.wstrb);

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level arbitration/response model.
module tb_imem_arbiter;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned SW          = XLEN / 8;
    localparam int unsigned D_BURST_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req, i_kill, i_gnt, i_rvalid, i_err;
    logic [ADDR_W-1:0] i_addr;
    logic [XLEN-1:0]   i_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [ADDR_W-1:0] d_addr;
    logic [XLEN-1:0]   d_wdata, d_rdata;
    logic [SW-1:0]     d_wstrb;
    logic              mem_req, mem_we, mem_ready, mem_valid, mem_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata, mem_rdata;
    logic [SW-1:0]     mem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    imem_arbiter #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .D_BURST_MAX(D_BURST_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0; i_kill = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_ready = 0; mem_valid = 0; mem_rdata = '0; mem_err = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // Memory side: called in the first ISSUE cycle; returns in the cycle the
    // response pulse is due (one cycle after mem_valid).
    task automatic mem_respond(input int rw, input int vw, input logic [XLEN-1:0] rd, input logic er);
        mem_rdata = rd;
        mem_err   = er;
        mem_valid = 0;
        repeat (rw) begin mem_ready = 0; tick(); end
        mem_ready = 1;
        mem_valid = (vw == 0);
        tick();
        mem_ready = 0;
        if (vw > 0) begin
            mem_valid = 0;
            repeat (vw - 1) tick();
            mem_valid = 1;
            tick();
        end
        mem_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        i_req = 1; d_req = 1; mem_valid = 1;
        tick();
        tick();
        n_checks++;
        if ({i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b/%b rvalid=%b/%b mem_req=%b addr=%h expected all zero",
                     i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_addr);
        end
        idle_inputs();
        reset = 0;
        tick();
        n_checks++;
        if ({i_gnt, d_gnt, mem_req, i_rvalid, d_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got gnt=%b/%b mem_req=%b expected 0", i_gnt, d_gnt, mem_req);
        end
    endtask

    task automatic test_i_only();
        logic d_seen = 0;
        do_reset();
        i_req = 1; i_addr = 32'h8000_0000;
        tick();
        d_seen |= d_gnt | d_rvalid;
        n_checks++;
        if (i_gnt !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_we !== 1'b0 || mem_wstrb !== '0) begin
            n_fail++;
            $display("FAIL i_only_grant: got gnt=%b req=%b addr=%h we=%b strb=%h expected 1 1 80000000 0 00",
                     i_gnt, mem_req, mem_addr, mem_we, mem_wstrb);
        end
        i_req = 0; mem_ready = 1;
        tick();
        d_seen |= d_gnt | d_rvalid;
        n_checks++;
        if (mem_req !== 1'b0 || i_rvalid !== 1'b0 || i_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL i_only_c2: got req=%b rvalid=%b gnt=%b expected 0 0 0", mem_req, i_rvalid, i_gnt);
        end
        mem_ready = 0; mem_valid = 1; mem_rdata = 64'h0072_6168_756C_2121;
        tick();
        d_seen |= d_gnt | d_rvalid;
        n_checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 64'h0072_6168_756C_2121 || i_err !== 1'b0) begin
            n_fail++;
            $display("FAIL i_only_resp: got rvalid=%b data=%h err=%b expected 1 00726168756c2121 0",
                     i_rvalid, i_rdata, i_err);
        end
        mem_valid = 0;
        tick();
        d_seen |= d_gnt | d_rvalid;
        n_checks++;
        if (i_rvalid !== 1'b0 || d_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL i_only_after: got rvalid=%b d_seen=%b expected 0 0", i_rvalid, d_seen);
        end
    endtask

    task automatic test_burst_order();
        logic exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   exp_cnt;
        do_reset();
        i_req = 1; i_addr = 32'h0000_4000;
        exp_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            d_req = 1; d_we = 0; d_addr = 32'h2000_0000 + 32'(k * 8);
            tick();
            n_checks++;
            if (d_gnt !== exp_d[k] || i_gnt !== !exp_d[k]) begin
                n_fail++;
                $display("FAIL burst_order[%0d]: got d_gnt=%b i_gnt=%b expected d_gnt=%b", k, d_gnt, i_gnt, exp_d[k]);
            end
            exp_cnt = (exp_d[k] && i_req) ? exp_cnt + 1 : 0;
            n_checks++;
            if (dut.u_prio.burst_cnt_q !== 4'(exp_cnt)) begin
                n_fail++;
                $display("FAIL burst_cnt[%0d]: got %0d expected %0d", k, dut.u_prio.burst_cnt_q, exp_cnt);
            end
            if (i_gnt) i_req = 0;
            if (d_gnt) d_req = 0;
            mem_respond(0, 1, 64'(k), 1'b0);
            tick();
        end
    endtask

    task automatic test_store_stall();
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h8000_1000;
        d_wdata = 64'hDEAD_BEEF_0000_0001; d_wstrb = 8'h0F;
        tick();
        d_req = 0; d_wdata = '0; d_addr = '0; d_wstrb = '0; d_we = 0;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h8000_1000 ||
                mem_wdata !== 64'hDEAD_BEEF_0000_0001 || mem_wstrb !== 8'h0F) begin
                n_fail++;
                $display("FAIL store_hold[%0d]: got req=%b we=%b addr=%h wdata=%h strb=%h expected 1 1 80001000 deadbeef00000001 0f",
                         c, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
            end
            mem_ready = (c == 4);
            tick();
        end
        mem_ready = 0;
        n_checks++;
        if (mem_req !== 1'b0 || d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_wait: got req=%b rvalid=%b expected 0 0", mem_req, d_rvalid);
        end
        mem_valid = 1; mem_rdata = 64'h55; mem_err = 0;
        tick();
        mem_valid = 0;
        n_checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 64'h55 || i_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_resp: got d_rvalid=%b data=%h i_rvalid=%b expected 1 55 0", d_rvalid, d_rdata, i_rvalid);
        end
    endtask

    task automatic test_kill();
        do_reset();
        i_req = 1; i_addr = 32'h8000_0100;
        tick();
        n_checks++;
        if (i_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_grant: got %b expected 1", i_gnt);
        end
        i_req = 0; mem_ready = 1;
        tick();
        mem_ready = 0; i_kill = 1;
        tick();
        i_kill = 0; mem_valid = 1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        mem_valid = 0;
        n_checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_resp: got i_rvalid=%b d_rvalid=%b expected 0 0", i_rvalid, d_rvalid);
        end
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h0000_0200;
        tick();
        n_checks++;
        if (d_gnt !== 1'b1 || mem_addr !== 32'h0000_0200 || i_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_next_d: got d_gnt=%b addr=%h i_rvalid=%b expected 1 00000200 0", d_gnt, mem_addr, i_rvalid);
        end
        d_req = 0;
        mem_respond(0, 1, 64'h1234, 1'b0);
        n_checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 64'h1234) begin
            n_fail++;
            $display("FAIL kill_d_resp: got rvalid=%b data=%h expected 1 1234", d_rvalid, d_rdata);
        end
        tick();
    endtask

    task automatic test_err_same_cycle();
        do_reset();
        d_req = 1; d_addr = 32'h0000_0300;
        tick();
        d_req = 0;
        mem_respond(0, 0, 64'hE0E0, 1'b1);
        n_checks++;
        if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 64'hE0E0 || i_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_d: got rvalid=%b err=%b data=%h i_rvalid=%b expected 1 1 e0e0 0",
                     d_rvalid, d_err, d_rdata, i_rvalid);
        end
        tick();
        i_req = 1; i_addr = 32'h0000_0400;
        tick();
        i_req = 0;
        mem_respond(0, 0, 64'hE1E1, 1'b1);
        n_checks++;
        if (i_rvalid !== 1'b1 || i_err !== 1'b1 || i_rdata !== 64'hE1E1 || d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_i: got rvalid=%b err=%b data=%h d_rvalid=%b expected 1 1 e1e1 0",
                     i_rvalid, i_err, i_rdata, d_rvalid);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        i_req = 1; i_addr = 32'h8000_0040;
        tick();
        i_req = 0; mem_ready = 1;
        tick();
        mem_ready = 0; reset = 1;
        tick();
        reset = 0;
        n_checks++;
        if ({i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL rst_wait_outputs: got mem_req=%b addr=%h gnt=%b expected all zero", mem_req, mem_addr, i_gnt);
        end
        mem_valid = 1; mem_rdata = 64'hFFFF;
        tick();
        mem_valid = 0;
        n_checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || mem_req !== 1'b0 || i_rdata !== '0) begin
            n_fail++;
            $display("FAIL rst_stray_valid: got i_rvalid=%b d_rvalid=%b mem_req=%b rdata=%h expected 0 0 0 0",
                     i_rvalid, d_rvalid, mem_req, i_rdata);
        end
        i_req = 1; i_addr = 32'h8000_0080;
        tick();
        n_checks++;
        if (i_gnt !== 1'b1 || mem_addr !== 32'h8000_0080) begin
            n_fail++;
            $display("FAIL rst_regrant: got gnt=%b addr=%h expected 1 80000080", i_gnt, mem_addr);
        end
        i_req = 0;
        mem_respond(1, 2, 64'h0BAD_F00D, 1'b0);
        n_checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 64'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL rst_regrant_resp: got rvalid=%b data=%h expected 1 0badf00d", i_rvalid, i_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int gnt_cycle = -1;
        do_reset();
        d_req = 1; d_addr = 32'h0000_1000;
        tick();
        n_checks++;
        if (d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got %b expected 1", d_gnt);
        end
        d_addr = 32'h0000_2000;
        mem_ready = 1;
        for (int c = 2; c <= 6 && gnt_cycle < 0; c++) begin
            tick();
            mem_ready = 0;
            mem_valid = (c == 2);
            if (d_gnt === 1'b1) gnt_cycle = c;
        end
        mem_valid = 0;
        n_checks++;
        if (gnt_cycle != 5 || mem_addr !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL b2b_period: got second grant at cycle %0d addr=%h expected cycle 5 addr 00002000", gnt_cycle, mem_addr);
        end
        d_req = 0;
        mem_respond(0, 1, 64'h2, 1'b0);
        tick();
    endtask

    // Randomized run: model picks the winner from the arbitration rules and
    // predicts the memory payload and the routed response.
    task automatic test_random();
        bit                ip = 0, dp = 0, win_d;
        int                d_streak = 0;
        int                rw, vw;
        logic [ADDR_W-1:0] ia = '0, da = '0;
        logic              dwe = 0, er;
        logic [XLEN-1:0]   dwd = '0, rd;
        logic [SW-1:0]     dws = '0;
        do_reset();
        for (int t = 0; t < 150; t++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1; ia = ADDR_W'($urandom) & ~32'h7;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; da = ADDR_W'($urandom); dwe = 1'($urandom_range(0, 1));
                dwd = {$urandom, $urandom}; dws = SW'($urandom);
            end
            if (!ip && !dp) begin
                ip = 1; ia = ADDR_W'($urandom) & ~32'h7;
            end
            i_req = ip; i_addr = ia;
            d_req = dp; d_addr = da; d_we = dwe; d_wdata = dwd; d_wstrb = dws;
            win_d = (ip && dp) ? (d_streak < int'(D_BURST_MAX)) : dp;
            if (!ip || !win_d) d_streak = 0;
            else               d_streak++;
            tick();
            n_checks++;
            if (d_gnt !== win_d || i_gnt !== !win_d || mem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got d_gnt=%b i_gnt=%b req=%b expected d_gnt=%b", t, d_gnt, i_gnt, mem_req, win_d);
            end
            n_checks++;
            if (win_d ? (mem_addr !== da || mem_we !== dwe || mem_wdata !== dwd || mem_wstrb !== dws)
                      : (mem_addr !== ia || mem_we !== 1'b0 || mem_wstrb !== '0)) begin
                n_fail++;
                $display("FAIL rand_payload[%0d]: got addr=%h we=%b strb=%h expected owner_d=%b", t, mem_addr, mem_we, mem_wstrb, win_d);
            end
            if (win_d) begin dp = 0; d_req = 0; end
            else       begin ip = 0; i_req = 0; end
            rd = {$urandom, $urandom};
            er = ($urandom_range(0, 3) == 0);
            rw = $urandom_range(0, 3);
            vw = $urandom_range(0, 3);
            mem_respond(rw, vw, rd, er);
            n_checks++;
            if (win_d ? (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== rd || d_err !== er)
                      : (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== rd || i_err !== er)) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: got i_rvalid=%b d_rvalid=%b i_rdata=%h d_rdata=%h expected owner_d=%b data=%h err=%b",
                         t, i_rvalid, d_rvalid, i_rdata, d_rdata, win_d, rd, er);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_burst_order();
        test_store_stall();
        test_kill();
        test_err_same_cycle();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
